// File: rtl/io_bus_initiator_pkg.sv
// Shared types for the peripheral I/O bus initiator: FSM encoding,
// queued request layout and the register offsets of the I/O block.
package io_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Register offsets of the GPIO/seg/LED/PS2/UART/VGA block.
  localparam logic [31:0] OFS_SW    = 32'h0000_0000;
  localparam logic [31:0] OFS_BTN   = 32'h0000_0004;
  localparam logic [31:0] OFS_SEG   = 32'h0000_0008;
  localparam logic [31:0] OFS_LED   = 32'h0000_000C;
  localparam logic [31:0] OFS_PS2D  = 32'h0000_0010;
  localparam logic [31:0] OFS_PS2C  = 32'h0000_0014;
  localparam logic [31:0] OFS_UARTD = 32'h0000_0018;
  localparam logic [31:0] OFS_UARTC = 32'h0000_001C;
  localparam logic [31:0] OFS_VGA0  = 32'h0000_0020;
  localparam logic [31:0] OFS_VGA1  = 32'h0000_0024;

  // Queued request: only the word address is kept, the byte offset is dropped.
  typedef struct packed {
    logic        write;
    logic [3:0]  be;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // Word address back to a word-aligned byte address.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/io_bus_initiator_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags derived from
// an occupancy counter. No bypass: a push while full is always refused.
module io_req_fifo
  import io_bus_initiator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REQ_W
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset since the flags guard every read.
  always_ff @(posedge clk_100M) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/io_bus_initiator.sv
// Peripheral I/O bus master: queues read/write requests and runs one
// registered bus transaction at a time, returning one response per request.
module io_bus_initiator
  import io_bus_initiator_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  output logic [3:0]  bus_we,
  output logic        bus_en,
  input  logic [31:0] bus_din,
  output logic        busy
);

  state_e      state_r, state_nx;
  logic        rdy_r;
  logic [31:0] bus_addr_r, bus_addr_nx;
  logic [31:0] bus_dout_r, bus_dout_nx;
  logic [3:0]  bus_we_r, bus_we_nx;
  logic        bus_en_r, bus_en_nx;
  logic        wr_r, wr_nx;
  logic [2:0]  cnt_r, cnt_nx;
  logic        rsp_valid_r, rsp_valid_nx;
  logic        rsp_write_r, rsp_write_nx;
  logic [31:0] rsp_rdata_r, rsp_rdata_nx;

  logic        fifo_full_s, fifo_empty_s, push_s, pop_s;
  req_t        push_req_s, head_s;
  logic        addr_lsb_unused_s;

  // Byte offset is not part of a word transaction.
  assign addr_lsb_unused_s = ^req_addr[1:0];

  // rdy_r keeps req_ready low for the cycle that follows a reset edge.
  assign req_ready  = rdy_r & ~fifo_full_s;
  assign push_s     = req_valid & req_ready;
  assign push_req_s = '{write: req_write, be: req_be, waddr: req_addr[31:2], wdata: req_wdata};
  assign busy       = ~fifo_empty_s | (state_r != ST_IDLE);

  io_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_req_fifo (
    .clk_100M (clk_100M),
    .rst      (rst),
    .push     (push_s),
    .wdata    (push_req_s),
    .pop      (pop_s),
    .rdata    (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Transaction sequencing: next state and next values of all registered outputs.
  always_comb begin
    state_nx     = state_r;
    bus_addr_nx  = bus_addr_r;
    bus_dout_nx  = bus_dout_r;
    bus_we_nx    = bus_we_r;
    bus_en_nx    = bus_en_r;
    wr_nx        = wr_r;
    cnt_nx       = cnt_r;
    rsp_valid_nx = rsp_valid_r;
    rsp_write_nx = rsp_write_r;
    rsp_rdata_nx = rsp_rdata_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          bus_addr_nx = word_to_byte_addr(head_s.waddr);
          bus_dout_nx = head_s.wdata;
          wr_nx       = head_s.write;
          bus_we_nx   = head_s.write ? head_s.be : 4'h0;
          bus_en_nx   = 1'b1;
          state_nx    = ST_ISSUE;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        bus_en_nx = 1'b0;
        bus_we_nx = 4'h0;
        cnt_nx    = 3'(RD_LAT - 1);
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        // bus_addr stays put here: the responder's read mux follows it.
        if (cnt_r == 3'd0) begin
          rsp_rdata_nx = wr_r ? 32'h0 : bus_din;
          rsp_write_nx = wr_r;
          rsp_valid_nx = 1'b1;
          state_nx     = ST_RESP;
        end else begin
          cnt_nx = cnt_r - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = ST_IDLE;
        end else begin
          state_nx     = ST_RESP;
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        bus_en_nx = 1'b0;
        bus_we_nx = 4'h0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rdy_r       <= 1'b0;
      bus_addr_r  <= 32'h0;
      bus_dout_r  <= 32'h0;
      bus_we_r    <= 4'h0;
      bus_en_r    <= 1'b0;
      wr_r        <= 1'b0;
      cnt_r       <= 3'd0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
    end else begin
      state_r     <= state_nx;
      rdy_r       <= 1'b1;
      bus_addr_r  <= bus_addr_nx;
      bus_dout_r  <= bus_dout_nx;
      bus_we_r    <= bus_we_nx;
      bus_en_r    <= bus_en_nx;
      wr_r        <= wr_nx;
      cnt_r       <= cnt_nx;
      rsp_valid_r <= rsp_valid_nx;
      rsp_write_r <= rsp_write_nx;
      rsp_rdata_r <= rsp_rdata_nx;
    end
  end

  assign bus_addr  = bus_addr_r;
  assign bus_dout  = bus_dout_r;
  assign bus_we    = bus_we_r;
  assign bus_en    = bus_en_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = rsp_write_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Bench for io_bus_initiator: a register-block responder per DUT, a
// request-level reference model (word array + expected-response queue),
// directed scenarios followed by a randomized request stream.
module tb_io_bus_initiator;
  import io_bus_initiator_pkg::*;

  logic clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  logic        rst, mem_init;
  logic        req_valid, req_valid3, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready, rsp_ready3;

  logic        req_ready, rsp_valid, rsp_write, bus_en, busy;
  logic [31:0] rsp_rdata, bus_addr, bus_dout, bus_din;
  logic [3:0]  bus_we;
  logic        req_ready3, rsp_valid3, rsp_write3, bus_en3, busy3;
  logic [31:0] rsp_rdata3, bus_addr3, bus_dout3, bus_din3;
  logic [3:0]  bus_we3;

  io_bus_initiator #(.DEPTH(4), .RD_LAT(1)) dut (
    .clk_100M(clk_100M), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .bus_en(bus_en),
    .bus_din(bus_din), .busy(busy)
  );

  io_bus_initiator #(.DEPTH(4), .RD_LAT(3)) dut3 (
    .clk_100M(clk_100M), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_write(rsp_write3), .rsp_rdata(rsp_rdata3),
    .bus_addr(bus_addr3), .bus_dout(bus_dout3), .bus_we(bus_we3), .bus_en(bus_en3),
    .bus_din(bus_din3), .busy(busy3)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h0000_00A5;
      9:       return 32'h00C0_FFEE;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Responder register blocks: bytes written on en, read data returned RD_LAT cycles later.
  logic [31:0] mem1 [10];
  logic [31:0] mem3 [10];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  logic [29:0] widx1, widx3;
  assign widx1    = bus_addr[31:2];
  assign widx3    = bus_addr3[31:2];
  assign bus_din  = pipe1;
  assign bus_din3 = pipe3[2];

  // Responder for the RD_LAT=1 instance.
  always @(posedge clk_100M) begin
    if (mem_init) begin
      for (int i = 0; i < 10; i++) mem1[i] <= init_val(i);
    end else if (bus_en && widx1 < 30'd10) begin
      mem1[widx1[3:0]] <= merge(mem1[widx1[3:0]], bus_dout, bus_we);
    end
    if (bus_en) pipe1 <= (widx1 < 30'd10) ? mem1[widx1[3:0]] : 32'h0;
  end

  // Responder for the RD_LAT=3 instance.
  always @(posedge clk_100M) begin
    if (mem_init) begin
      for (int i = 0; i < 10; i++) mem3[i] <= init_val(i);
    end else if (bus_en3 && widx3 < 30'd10) begin
      mem3[widx3[3:0]] <= merge(mem3[widx3[3:0]], bus_dout3, bus_we3);
    end
    if (bus_en3) pipe3[0] <= (widx3 < 30'd10) ? mem3[widx3[3:0]] : 32'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  // Reference model and bookkeeping (owned by the initial block).
  logic [31:0] model_mem [10];
  logic [32:0] exp_q [$];
  int n_pass = 0, n_total = 0;
  int cyc = 0, en_count = 0, rise_cyc = -1, rise3_cyc = -1, push_cyc = 0, push3_cyc = 0;
  logic prev_en = 1'b0, prev_rsp = 1'b0, prev_rsp3 = 1'b0, acc_s, acc3_s, rand_rdy = 1'b0;
  logic [31:0] en_addr = 32'h0, last_rdata = 32'h0, rise3_data = 32'h0;
  logic [3:0]  we_seen = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    int idx;
    idx = int'(a[31:2]);
    if (w) begin
      if (idx < 10) model_mem[idx] = merge(model_mem[idx], d, be);
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      exp_q.push_back({1'b0, (idx < 10) ? model_mem[idx] : 32'h0});
    end
  endtask

  // One clock: sample/score outputs at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk_100M);
    acc_s  = req_valid && req_ready && !rst;
    acc3_s = req_valid3 && req_ready3 && !rst;
    if (!rst) begin
      if (bus_en) begin
        en_count++;
        en_addr = bus_addr;
        if (bus_we != 4'h0) we_seen = bus_we;
        check("en_single_cycle", {31'b0, prev_en}, 32'h0);
      end else begin
        check("we_outside_issue", {28'b0, bus_we}, 32'h0);
      end
      prev_en = bus_en;
      if (rsp_valid && !prev_rsp) rise_cyc = cyc;
      prev_rsp = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", {31'b0, rsp_write}, {31'b0, e[32]});
          check("rsp_rdata", rsp_rdata, e[31:0]);
          last_rdata = rsp_rdata;
        end
      end
      if (rsp_valid3 && !prev_rsp3) begin
        rise3_cyc  = cyc;
        rise3_data = rsp_rdata3;
      end
      prev_rsp3 = rsp_valid3;
    end else begin
      prev_en = 1'b0; prev_rsp = 1'b0; prev_rsp3 = 1'b0;
    end
    @(posedge clk_100M);
    #1;
    cyc++;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int bound, output logic ok);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc_s) begin
        ok = 1'b1;
        push_cyc = cyc;
        model_push(w, a, d, be);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic push_must(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input int bound);
    logic ok;
    push(w, a, d, be, bound, ok);
    check(tag, {31'b0, ok}, 32'h1);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) cycle();
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int e0;
    logic ok, found;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    for (int i = 0; i < 10; i++) model_mem[i] = init_val(i);
    repeat (3) begin @(posedge clk_100M); #1; end

    // Reset values while rst is held.
    check("rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_write", {31'b0, rsp_write}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_dout", bus_dout, 32'h0);
    check("rst_bus_we", {28'b0, bus_we}, 32'h0);
    check("rst_bus_en", {31'b0, bus_en}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_busy3", {31'b0, busy3}, 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    cycle();
    check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("post_rst_req_ready3", {31'b0, req_ready3}, 32'h1);

    // Latency, RD_LAT=1: read SW.
    rise_cyc = -1;
    push_must("lat1_push", 1'b0, OFS_SW, 32'h0, 4'h0, 5);
    e0 = push_cyc;
    drain(20);
    check("lat1_cycles", 32'(rise_cyc - e0), 32'd3);
    check("lat1_rdata", last_rdata, 32'h0000_00A5);

    // Latency, RD_LAT=3: read SW on the second instance.
    req_valid3 = 1'b1; req_write = 1'b0; req_addr = OFS_SW; req_be = 4'h0;
    cycle();
    check("lat3_push", {31'b0, acc3_s}, 32'h1);
    push3_cyc = cyc;
    req_valid3 = 1'b0;
    repeat (12) cycle();
    check("lat3_cycles", 32'(rise3_cyc - push3_cyc), 32'd5);
    check("lat3_rdata", rise3_data, 32'h0000_00A5);

    // Write then read SEG.
    e0 = en_count; we_seen = 4'h0;
    push_must("wr_push", 1'b1, OFS_SEG, 32'h1234_5678, 4'hF, 5);
    push_must("rd_push", 1'b0, OFS_SEG, 32'h0, 4'h0, 5);
    drain(40);
    check("wr_rd_en_pulses", 32'(en_count - e0), 32'd2);
    check("wr_rd_we", {28'b0, we_seen}, 32'hF);
    check("wr_rd_rdata", last_rdata, 32'h1234_5678);

    // Partial byte enables into LED (holds 0).
    push_must("be_wr_push", 1'b1, OFS_LED, 32'hAABB_CCDD, 4'b0101, 5);
    push_must("be_rd_push", 1'b0, OFS_LED, 32'h0, 4'h0, 5);
    drain(40);
    check("be_rdata", last_rdata, 32'h00BB_00DD);

    // Unaligned address into VGA1.
    push_must("align_push", 1'b0, 32'h0000_0027, 32'h0, 4'h0, 5);
    drain(20);
    check("align_bus_addr", en_addr, 32'h0000_0024);
    check("align_rdata", last_rdata, 32'h00C0_FFEE);

    // FIFO full with response backpressure; responses must come back in order.
    rsp_ready = 1'b0; e0 = en_count;
    push_must("full_p1", 1'b1, OFS_SEG, 32'h1111_1111, 4'hF, 10);
    push_must("full_p2", 1'b0, OFS_SEG, 32'h0, 4'h0, 10);
    push_must("full_p3", 1'b1, OFS_SEG, 32'h2222_2222, 4'b0011, 10);
    push_must("full_p4", 1'b0, OFS_SEG, 32'h0, 4'h0, 10);
    push_must("full_p5", 1'b0, OFS_SW, 32'h0, 4'h0, 10);
    push(1'b0, OFS_SEG, 32'h0, 4'h0, 6, ok);
    check("full_refused", {31'b0, ok}, 32'h0);
    check("full_req_ready", {31'b0, req_ready}, 32'h0);
    check("full_single_en", 32'(en_count - e0), 32'd1);
    check("full_rsp_held", {31'b0, rsp_valid}, 32'h1);
    rsp_ready = 1'b1;
    push_must("full_p6", 1'b0, OFS_SEG, 32'h0, 4'h0, 60);
    drain(100);
    check("full_total_en", 32'(en_count - e0), 32'd6);

    // Reset during ISSUE with three requests still queued.
    rsp_ready = 1'b0;
    push_must("rst_dummy", 1'b0, OFS_SW, 32'h0, 4'h0, 10);
    for (int i = 1; i <= 4; i++) push_must("rst_fill", 1'b0, 32'(4 * i), 32'h0, 4'h0, 10);
    rsp_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus_en) found = 1'b1;
    end
    check("rst_issue_found", {31'b0, found}, 32'h1);
    rst = 1'b1;
    exp_q.delete();
    cycle();
    check("abort_bus_en", {31'b0, bus_en}, 32'h0);
    check("abort_bus_we", {28'b0, bus_we}, 32'h0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_req_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b0;
    e0 = en_count;
    repeat (20) cycle();
    check("abort_no_en", 32'(en_count - e0), 32'd0);
    check("abort_idle_busy", {31'b0, busy}, 32'h0);
    check("abort_req_ready_back", {31'b0, req_ready}, 32'h1);

    // Randomized request stream with random response backpressure.
    rand_rdy = 1'b1; e0 = en_count;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'(4 * $urandom_range(0, 9)) | 32'($urandom_range(0, 3));
      push_must("rand_push", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 100);
    end
    rand_rdy = 1'b0; rsp_ready = 1'b1;
    drain(200);
    check("rand_en_count", 32'(en_count - e0), 32'd40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
